// File: rtl/cnn_pkg.sv
// Shared types, pooling constants and signed max helper for the CNN datapath.
package cnn_pkg;
    localparam int unsigned POOL_K = 2;
    localparam int unsigned POOL_S = 2;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned MAX_W  = 64;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [MAX_W-1:0]  wide_t;

    // Callers sign-extend narrower words into wide_t, so one helper serves any width up to MAX_W.
    function automatic wide_t max_s(input wide_t a, input wide_t b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/cnn_pool_linebuf.sv
// One line of partial 2x2 maxima: register file, one write port, one combinational read port.
module cnn_pool_linebuf #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Every entry is written on an even row before the odd row reads it, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/cnn_relu_pool.sv
// ReLU followed by 2x2/stride-2 max pooling over a raster stream of Tm_p parallel channels.
module cnn_relu_pool
    import cnn_pkg::*;
#(
    parameter int unsigned Tm_p = 2,
    parameter int unsigned R_p  = 16,
    parameter int unsigned C_p  = 16,
    parameter int unsigned W_p  = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [Tm_p*W_p-1:0] data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [Tm_p*W_p-1:0] data_o,
    output logic                last_o
);
    localparam int unsigned OUT_COLS = C_p / POOL_S;
    localparam int unsigned ROW_W    = $clog2(R_p);
    localparam int unsigned COL_W    = $clog2(C_p);
    localparam int unsigned ADDR_W   = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam int unsigned LB_W     = Tm_p * W_p;

    if ((R_p % POOL_K) != 0 || R_p < POOL_K) begin : g_bad_rows
        $error("cnn_relu_pool: R_p must be even and at least 2");
    end
    if ((C_p % POOL_K) != 0 || C_p < POOL_K) begin : g_bad_cols
        $error("cnn_relu_pool: C_p must be even and at least 2");
    end
    if (Tm_p < 1) begin : g_bad_tm
        $error("cnn_relu_pool: Tm_p must be at least 1");
    end

    function automatic logic signed [W_p-1:0] smax(input logic signed [W_p-1:0] a,
                                                    input logic signed [W_p-1:0] b);
        return W_p'(max_s(MAX_W'(a), MAX_W'(b)));
    endfunction

    logic [ROW_W-1:0]      row_r;
    logic [COL_W-1:0]      col_r;
    logic signed [W_p-1:0] hold_r [Tm_p];
    logic signed [W_p-1:0] relu_x [Tm_p];
    logic signed [W_p-1:0] hx_max [Tm_p];
    logic                  accept, row_odd, col_odd, row_end, col_end;
    logic [ADDR_W-1:0]     lb_addr;
    logic [LB_W-1:0]       lb_wdata, lb_rdata, pool_data;

    assign ready_o = ~valid_o | ready_i;
    assign accept  = valid_i & ready_o;
    assign row_odd = row_r[0];
    assign col_odd = col_r[0];
    assign row_end = (row_r == ROW_W'(R_p - 1));
    assign col_end = (col_r == COL_W'(C_p - 1));
    assign lb_addr = ADDR_W'(col_r >> 1);

    // hold_r is always >= 0, so max(hold, x) already carries the ReLU seed.
    always_comb begin
        lb_wdata  = '0;
        pool_data = '0;
        relu_x    = '{default: '0};
        hx_max    = '{default: '0};
        for (int unsigned ch = 0; ch < Tm_p; ch++) begin
            relu_x[ch] = smax('0, $signed(data_i[ch*W_p +: W_p]));
            hx_max[ch] = smax(hold_r[ch], $signed(data_i[ch*W_p +: W_p]));
            lb_wdata[ch*W_p +: W_p]  = hx_max[ch];
            pool_data[ch*W_p +: W_p] = smax(hx_max[ch], $signed(lb_rdata[ch*W_p +: W_p]));
        end
    end

    cnn_pool_linebuf #(
        .DEPTH  (OUT_COLS),
        .WIDTH  (LB_W),
        .ADDR_W (ADDR_W)
    ) u_linebuf (
        .clk_i   (clk_i),
        .we_i    (accept & ~row_odd & col_odd),
        .waddr_i (lb_addr),
        .wdata_i (lb_wdata),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            row_r <= '0;
            col_r <= '0;
        end else if (accept) begin
            if (col_end) begin
                col_r <= '0;
                row_r <= row_end ? '0 : row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned ch = 0; ch < Tm_p; ch++) begin
                hold_r[ch] <= '0;
            end
        end else if (accept & ~col_odd) begin
            for (int unsigned ch = 0; ch < Tm_p; ch++) begin
                hold_r[ch] <= relu_x[ch];
            end
        end
    end

    // A load wins over the clear, giving back-to-back outputs on a simultaneous transfer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            data_o  <= '0;
        end else if (accept & row_odd & col_odd) begin
            valid_o <= 1'b1;
            last_o  <= row_end & col_end;
            data_o  <= pool_data;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cnn_relu_pool.sv
// Randomised and directed bench for cnn_relu_pool against a whole-frame window-max reference model.
module tb_cnn_relu_pool;
    import cnn_pkg::*;

    localparam int TM = 2;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int W  = 16;

    logic          clk     = 1'b0;
    logic          reset_i = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [TM*W-1:0] data_i = '0;
    logic          ready_o, valid_o, last_o;
    logic [TM*W-1:0] data_o;

    always #5 clk = ~clk;

    cnn_relu_pool #(
        .Tm_p (TM),
        .R_p  (R),
        .C_p  (C),
        .W_p  (W)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .last_o  (last_o)
    );

    typedef struct {
        data_t d0;
        data_t d1;
        bit    last;
        int    mode;
        int    k;
    } exp_t;

    exp_t  expq[$];
    data_t fmem [R][C][TM];
    int    checks = 0;
    int    errors = 0;
    bit    exp_valid = 1'b0;
    int    pos = 0;
    int    n_out = 0;
    int    n_last = 0;
    int    bp_left = 0;
    bit    bp_done = 1'b0;
    int    exp_basic[4] = '{5, 7, 13, 15};

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: basic frame, 1: offset frame, 2: random, 3: signed extremes
    function automatic data_t src(input int m, input int r, input int c, input int ch);
        int v;
        int idx;
        v = r * C + c;
        case (m)
            0: return (ch == 0) ? data_t'(v) : data_t'(-v);
            1: return (ch == 0) ? data_t'(100 + v) : data_t'(-v);
            3: begin
                if (ch == 1) return data_t'(-1);
                idx = (r % 2) * 2 + (c % 2);
                case (idx)
                    0: return data_t'(-32768);
                    1: return data_t'(32767);
                    2: return data_t'(-1);
                    default: return data_t'(0);
                endcase
            end
            default: return data_t'($urandom);
        endcase
    endfunction

    function automatic data_t max0(input data_t a, input data_t b, input data_t c, input data_t d);
        int m;
        m = 0;
        if (int'(a) > m) m = a;
        if (int'(b) > m) m = b;
        if (int'(c) > m) m = c;
        if (int'(d) > m) m = d;
        return data_t'(m);
    endfunction

    task automatic tick(input bit v, input bit r, input int m, output bit acc);
        int    rr, cc;
        data_t d0, d1;
        bit    xfer, load;
        exp_t  e;
        rr = pos / C;
        cc = pos % C;
        d0 = src(m, rr, cc, 0);
        d1 = src(m, rr, cc, 1);
        valid_i = v;
        ready_i = r;
        data_i  = {d1, d0};
        @(negedge clk);
        chk("valid_o", valid_o, exp_valid);
        chk("ready_o", ready_o, (!exp_valid || r));
        if (exp_valid && expq.size() > 0) begin
            chk("data_ch0", $signed(data_o[W-1:0]), expq[0].d0);
            chk("data_ch1", $signed(data_o[2*W-1:W]), expq[0].d1);
            chk("last_o", last_o, expq[0].last);
        end
        xfer = exp_valid && r;
        acc  = v && (!exp_valid || r);
        load = 1'b0;
        if (xfer && expq.size() > 0) begin
            e = expq.pop_front();
            n_out++;
            if (e.last) n_last++;
            if (e.mode == 0) begin
                chk("basic_ch0", $signed(data_o[W-1:0]), exp_basic[e.k]);
                chk("basic_ch1", $signed(data_o[2*W-1:W]), 0);
            end else if (e.mode == 1) begin
                chk("frame2_ch0", $signed(data_o[W-1:0]), exp_basic[e.k] + 100);
            end else if (e.mode == 3) begin
                chk("extreme_ch0", $signed(data_o[W-1:0]), 32767);
                chk("extreme_ch1", $signed(data_o[2*W-1:W]), 0);
            end
        end
        if (acc) begin
            fmem[rr][cc][0] = d0;
            fmem[rr][cc][1] = d1;
            if ((rr % 2 == 1) && (cc % 2 == 1)) begin
                e.d0   = max0(fmem[rr-1][cc-1][0], fmem[rr-1][cc][0], fmem[rr][cc-1][0], fmem[rr][cc][0]);
                e.d1   = max0(fmem[rr-1][cc-1][1], fmem[rr-1][cc][1], fmem[rr][cc-1][1], fmem[rr][cc][1]);
                e.last = (rr == R - 1) && (cc == C - 1);
                e.mode = m;
                e.k    = (rr / 2) * (C / 2) + cc / 2;
                expq.push_back(e);
                load = 1'b1;
            end
            pos = (pos + 1) % (R * C);
        end
        if (load) exp_valid = 1'b1;
        else if (xfer) exp_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // vm: 0 valid always high, 1 random; rm: 0 ready high, 1 random, 2 one 5-cycle stall at first output
    task automatic run_beats(input int n, input int m, input int vm, input int rm);
        int got;
        int cyc;
        bit v, r, acc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 4000) begin
            v = (vm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            case (rm)
                0: r = 1'b1;
                1: r = 1'($urandom_range(0, 1));
                default: begin
                    if (!bp_done && exp_valid) begin
                        bp_done = 1'b1;
                        bp_left = 5;
                    end
                    r = (bp_left == 0);
                    if (bp_left > 0) bp_left--;
                end
            endcase
            tick(v, r, m, acc);
            if (acc) got++;
            cyc++;
        end
        if (got < n) chk("beat_timeout", got, n);
    endtask

    task automatic drain(input int rm);
        int cyc;
        bit acc;
        bit r;
        cyc = 0;
        while (exp_valid && cyc < 200) begin
            r = (rm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tick(1'b0, r, 0, acc);
            cyc++;
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        expq.delete();
        exp_valid = 1'b0;
        pos = 0;
        chk("reset_valid", valid_o, 0);
        chk("reset_last", last_o, 0);
        chk("reset_data", data_o, 0);
    endtask

    initial begin
        do_reset();

        n_out = 0; n_last = 0;
        run_beats(16, 0, 0, 0);
        drain(0);
        chk("basic_count", n_out, 4);
        chk("basic_lasts", n_last, 1);

        n_out = 0; n_last = 0; bp_done = 1'b0;
        run_beats(16, 0, 0, 2);
        drain(0);
        chk("bp_count", n_out, 4);
        chk("bp_lasts", n_last, 1);

        n_out = 0; n_last = 0;
        run_beats(16, 0, 1, 0);
        drain(0);
        chk("gaps_count", n_out, 4);
        chk("gaps_lasts", n_last, 1);

        n_out = 0; n_last = 0;
        run_beats(16, 3, 0, 1);
        drain(1);
        chk("extreme_count", n_out, 4);

        run_beats(6, 0, 0, 0);
        do_reset();
        n_out = 0; n_last = 0;
        run_beats(16, 0, 0, 0);
        drain(0);
        chk("rst_count", n_out, 4);
        chk("rst_lasts", n_last, 1);

        n_out = 0; n_last = 0;
        run_beats(16, 0, 0, 0);
        run_beats(16, 1, 0, 0);
        drain(0);
        chk("b2b_count", n_out, 8);
        chk("b2b_lasts", n_last, 2);

        n_out = 0; n_last = 0;
        repeat (4) run_beats(16, 2, 1, 1);
        drain(1);
        chk("rand_count", n_out, 16);
        chk("rand_lasts", n_last, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnn_relu_pool.md
Name: cnn_relu_pool

Overview:
- Downstream stage of the cnn top.
- Consumes the output-feature-map stream that the cnn top produces for Tm_p channels in parallel, one (row, col) position per beat in raster order.
- Applies ReLU, then 2x2 max-pooling with stride 2, and emits pooled pixels over a valid/ready handshake to the next layer's input buffer.
- Fully streaming. Holds only one line of partial maxima per channel.

Parameters:
- Tm_p, 2, channels processed in parallel per beat (matches cnn Tm_p)
- R_p, 16, input frame rows; must be even, at least 2
- C_p, 16, input frame columns; must be even, at least 2
- W_p, 16, data width; signed two's-complement fixed point

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  synchronous, active-high reset
- valid_i  in  1  input beat valid
- ready_o  out  1  block can accept an input beat
- data_i  in  Tm_p x W_p  one pixel position, all Tm_p channels
- valid_o  out  1  pooled output valid
- ready_i  in  1  downstream accepts output
- data_o  out  Tm_p x W_p  pooled, ReLU'd pixel, all channels
- last_o  out  1  data_o is the final pooled pixel of the frame (row R_p/2-1, col C_p/2-1)

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-high on reset_i; polarity and synchronicity are fixed.
- Handshake:
  - Input beat accepted when valid_i & ready_o.
  - Output transfer occurs when valid_o & ready_i.
  - ready_o = ~valid_o | ready_i. This is combinational and deliberately conservative: it applies to every beat, not only output-producing beats.
  - data_o and last_o hold stable while valid_o & ~ready_i.
- Counters:
  - row_r in 0..R_p-1 and col_r in 0..C_p-1 advance only on accepted beats.
  - col_r wraps to 0 after C_p-1 and increments row_r.
  - row_r wraps to 0 after R_p-1, so frames run back-to-back with no idle cycle.
- ReLU: every element is treated as max(x, 0) using a signed compare. The running max is seeded with 0, so the result is max(0, four window values).
- Even row, even col: hold_r[ch] <= max(0, x).
- Even row, odd col: linebuf[col_r>>1][ch] <= max(hold_r[ch], x).
- Odd row, even col: hold_r[ch] <= max(0, x).
- Odd row, odd col:
  - data_o[ch] <= max(hold_r[ch], x, linebuf[col_r>>1][ch]).
  - valid_o <= 1.
  - last_o <= (row_r==R_p-1 && col_r==C_p-1).
- Latency: valid_o rises on the cycle after the odd-row/odd-col beat is accepted.
- valid_o clears after a transfer unless a new pooled result loads in the same cycle. That simultaneous transfer-and-load is legal and yields back-to-back outputs.
- Throughput: 1 input beat per cycle when ready_i is held high. Output rate is 1 per 4 inputs on average.
- linebuf holds C_p/2 x Tm_p x W_p bits. Each entry is written on an even row before it is read on the following odd row, so it needs no reset.
- Reset:
  - row_r, col_r, hold_r, valid_o, last_o and data_o go to 0.
  - Reset mid-frame discards the partial frame.
  - The first accepted beat after reset is (0,0).
- Arithmetic: all compares are signed W_p-bit. No width growth, no saturation needed.
- Output count: exactly (R_p/2)*(C_p/2) outputs per frame, with last_o asserted on exactly one of them.
- Elaboration assertions: R_p and C_p are even; Tm_p >= 1.

Decomposition:
- cnn_pkg:
  - typedef logic signed [W_p-1:0] for the data word.
  - A max-of-signed function.
  - Pooling window/stride constants POOL_K=2, POOL_S=2.
- Sub-module cnn_pool_linebuf: a C_p/2-deep, Tm_p*W_p-wide register-file line buffer with one write port and one combinational read port, addressed by col_r>>1.
- Counters and handshake stay in cnn_relu_pool.

Test Plan:
- Basic pooling and ReLU:
  - Setup: R_p=C_p=4, Tm_p=2. ch0 = row*4+col, ch1 = -(row*4+col). valid_i always high, ready_i always high.
  - Expected: outputs ch0 = 5, 7, 13, 15; ch1 = 0, 0, 0, 0. last_o only on the 4th output. Each valid_o appears 1 cycle after input beats 6, 8, 14 and 16 (counting from 1).
- Backpressure:
  - Stimulus: same frame; hold ready_i low for 5 cycles starting when the first valid_o rises.
  - Expected: data_o stays 5/0; ready_o stays low for those 5 cycles; no beat is lost; the output sequence matches the basic pooling case.
- Input gaps:
  - Stimulus: valid_i toggled in a pseudo-random pattern, 50% duty.
  - Expected: identical output values and order as the basic pooling case; counters advance only on accepted beats.
- Signed extremes:
  - Stimulus: window {-32768, 32767, -1, 0} on ch0 and window {-1, -1, -1, -1} on ch1.
  - Expected: ch0 = 32767; ch1 = 0.
- Reset mid-frame:
  - Stimulus: assert reset_i for 1 cycle after 6 accepted beats, then send a full basic-pooling frame.
  - Expected: valid_o is 0 after reset; exactly 4 outputs 5, 7, 13, 15.
- Back-to-back frames:
  - Stimulus: two frames with no idle cycle; the second frame is ch0 = 100 + row*4 + col.
  - Expected: second-frame outputs 105, 107, 113, 115; last_o pulses twice in total.
